// File: rtl/nes_joypad_port.sv
// NES controller port: two 4021-style latch/shift registers with X/Y autofire.
// Optional NES_JOYPAD_SWAP_EN adds a joy_swap input that exchanges the port sources.
module nes_joypad_port #(
    parameter int unsigned FREQ        = 21_492_000,
    parameter int unsigned AUTOFIRE_HZ = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] joy1,
    input  logic [11:0] joy2,
    input  logic        joypad_strobe,
    input  logic [1:0]  joypad_clock,
`ifdef NES_JOYPAD_SWAP_EN
    input  logic        joy_swap,
`endif
    output logic        joypad1_data,
    output logic        joypad2_data,
    output logic [3:0]  shift_cnt1,
    output logic [3:0]  shift_cnt2
);

    localparam int unsigned HALF = FREQ / (2 * AUTOFIRE_HZ);
    localparam int unsigned CntW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(HALF - 1);

    logic [11:0]           joy1_s1_q, joy1_s2_q, joy2_s1_q, joy2_s2_q;
    logic                  swap_s1_q, swap_s2_q, swap_in;
    logic [CntW-1:0]       af_cnt_q, af_cnt_d;
    logic                  phase_q, phase_d;
    logic [1:0]            last_clock_q;
    logic [1:0][7:0]       sr_q, sr_d;
    logic [1:0][3:0]       cnt_q, cnt_d;
    logic [1:0]            data_q, data_d;
    logic [1:0][11:0]      src;
    logic [1:0][7:0]       latch_val;
    logic                  unused_bits;

`ifdef NES_JOYPAD_SWAP_EN
    assign swap_in = joy_swap;
`else
    assign swap_in = 1'b0;
`endif

    // Only the low ten buttons reach the NES; R/L are ignored.
    assign unused_bits = ^{joy1_s2_q[11:10], joy2_s2_q[11:10]};

    always_comb begin
        af_cnt_d = af_cnt_q + 1'b1;
        phase_d  = phase_q;
        if (af_cnt_q == CntMax) begin
            af_cnt_d = '0;
            phase_d  = ~phase_q;
        end

        src[0] = swap_s2_q ? joy2_s2_q : joy1_s2_q;
        src[1] = swap_s2_q ? joy1_s2_q : joy2_s2_q;

        sr_d  = sr_q;
        cnt_d = cnt_q;
        for (int n = 0; n < 2; n++) begin
            latch_val[n] = {src[n][7:2], src[n][1] | (src[n][9] & phase_q),
                            src[n][0] | (src[n][8] & phase_q)};
            // Strobe has priority over a coincident falling clock edge.
            if (joypad_strobe) begin
                sr_d[n]  = latch_val[n];
                cnt_d[n] = 4'd0;
            end else if (last_clock_q[n] && !joypad_clock[n]) begin
                sr_d[n]  = {1'b1, sr_q[n][7:1]};
                cnt_d[n] = (cnt_q[n] >= 4'd8) ? 4'd8 : cnt_q[n] + 4'd1;
            end
            data_d[n] = sr_q[n][0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            joy1_s1_q    <= '0;
            joy1_s2_q    <= '0;
            joy2_s1_q    <= '0;
            joy2_s2_q    <= '0;
            swap_s1_q    <= 1'b0;
            swap_s2_q    <= 1'b0;
            af_cnt_q     <= '0;
            phase_q      <= 1'b0;
            last_clock_q <= 2'b00;
            sr_q         <= {2{8'hFF}};
            cnt_q        <= '0;
            data_q       <= 2'b11;
        end else begin
            joy1_s1_q    <= joy1;
            joy1_s2_q    <= joy1_s1_q;
            joy2_s1_q    <= joy2;
            joy2_s2_q    <= joy2_s1_q;
            swap_s1_q    <= swap_in;
            swap_s2_q    <= swap_s1_q;
            af_cnt_q     <= af_cnt_d;
            phase_q      <= phase_d;
            last_clock_q <= joypad_clock;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
        end
    end

    assign joypad1_data = data_q[0];
    assign joypad2_data = data_q[1];
    assign shift_cnt1   = cnt_q[0];
    assign shift_cnt2   = cnt_q[1];

endmodule

// File: tb/tb_nes_joypad_port.sv
// Scoreboard bench for nes_joypad_port (HALF = 10 autofire configuration).
module tb_nes_joypad_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] joy1, joy2;
    logic        joypad_strobe;
    logic [1:0]  joypad_clock;
    logic        joy_swap;
    logic        joypad1_data, joypad2_data;
    logic [3:0]  shift_cnt1, shift_cnt2;

    int total = 0;
    int bad   = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    nes_joypad_port #(.FREQ(1000), .AUTOFIRE_HZ(50)) dut (
        .clk          (clk),
        .reset        (reset),
        .joy1         (joy1),
        .joy2         (joy2),
        .joypad_strobe(joypad_strobe),
        .joypad_clock (joypad_clock),
`ifdef NES_JOYPAD_SWAP_EN
        .joy_swap     (joy_swap),
`endif
        .joypad1_data (joypad1_data),
        .joypad2_data (joypad2_data),
        .shift_cnt1   (shift_cnt1),
        .shift_cnt2   (shift_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_latch();
        joypad_strobe = 1'b1;
        tick(2);
        joypad_strobe = 1'b0;
        tick(3);
    endtask

    task automatic fall(input int p);
        joypad_clock[p] = 1'b1;
        tick(2);
        joypad_clock[p] = 1'b0;
        tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   last_edge, ngaps, ones, zeros;
        logic prev, d0, d1;

        reset = 1'b1; joy1 = 12'hFFF; joy2 = 12'h000; joy_swap = 1'b0;
        joypad_strobe = 1'b0; joypad_clock = 2'b00;
        tick(3);
        check("rst_d1", joypad1_data, 1);
        check("rst_d2", joypad2_data, 1);
        check("rst_c1", shift_cnt1, 0);
        check("rst_c2", shift_cnt2, 0);
        reset = 1'b0;

        // Basic read: A + START
        joy1 = 12'h009; joy2 = 12'h000;
        tick(4);
        do_latch();
        foreach (exp_q[i]) ;
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(1); exp_q.push_back(1);
        for (int i = 0; i < 10; i++) begin
            check("rd1_bit", joypad1_data, exp_q.pop_front());
            check("rd1_cnt", shift_cnt1, (i > 8) ? 8 : i);
            fall(0);
        end
        check("rd1_sat", shift_cnt1, 8);
        check("rd1_p2cnt", shift_cnt2, 0);
        check("rd1_p2dat", joypad2_data, 0);

        // Strobe held on port 2
        joypad_strobe = 1'b1; joy2 = 12'h001;
        tick(4);
        for (int i = 0; i < 5; i++) fall(1);
        check("hold_d2", joypad2_data, 1);
        check("hold_c2", shift_cnt2, 0);
        joy2 = 12'h000;
        tick(5);
        check("hold_d2_off", joypad2_data, 0);
        joypad_strobe = 1'b0;

        // Collision: strobe and falling edge on the same clk
        joy1 = 12'h001;
        tick(4);
        do_latch();
        fall(0);
        check("col_pre_cnt", shift_cnt1, 1);
        check("col_pre_dat", joypad1_data, 0);
        joypad_clock[0] = 1'b1;
        tick(2);
        joypad_clock[0] = 1'b0;
        joypad_strobe = 1'b1;
        tick(1);
        joypad_strobe = 1'b0;
        tick(3);
        check("col_cnt", shift_cnt1, 0);
        check("col_dat", joypad1_data, 1);

        // Reset mid-read is immediate
        fall(0); fall(0);
        reset = 1'b1;
        #1;
        check("mid_rst_cnt", shift_cnt1, 0);
        check("mid_rst_dat", joypad1_data, 1);
        tick(2);
        reset = 1'b0;
        tick(1);

        // Autofire A: data toggles every HALF = 10 clk while strobe held
        joy1 = 12'h100; joypad_strobe = 1'b1;
        tick(5);
        prev = joypad1_data; last_edge = -1; ngaps = 0;
        for (int t = 0; t < 65; t++) begin
            tick(1);
            if (joypad1_data !== prev) begin
                if (last_edge >= 0) begin
                    check("af_gap", t - last_edge, 10);
                    ngaps++;
                end
                last_edge = t;
                prev = joypad1_data;
            end
        end
        check("af_ngaps", (ngaps >= 4), 1);
        joypad_strobe = 1'b0;

        // Autofire B follows the same phase as A
        joy1 = 12'h300;
        tick(4);
        for (int k = 0; k < 8; k++) begin
            tick(k * 3);
            do_latch();
            d0 = joypad1_data;
            fall(0);
            d1 = joypad1_data;
            check("afb_eq", d1, d0);
        end
        joy1 = 12'h200;
        tick(4);
        ones = 0; zeros = 0;
        for (int k = 0; k < 12; k++) begin
            do_latch();
            check("afb_a0", joypad1_data, 0);
            fall(0);
            if (joypad1_data) ones++; else zeros++;
            tick(4);
        end
        check("afb_ones", (ones > 0), 1);
        check("afb_zeros", (zeros > 0), 1);

`ifdef NES_JOYPAD_SWAP_EN
        joy1 = 12'h001; joy2 = 12'h000; joy_swap = 1'b1;
        tick(4);
        do_latch();
        check("sw_d1", joypad1_data, 0);
        check("sw_d2", joypad2_data, 1);
        joy1 = 12'h00A; joy2 = 12'h005; joy_swap = 1'b0;
        tick(4);
        do_latch();
        joy_swap = 1'b1;
        tick(4);
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
        for (int i = 0; i < 4; i++) begin
            check("sw_mid", joypad1_data, exp_q.pop_front());
            fall(0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
